seq_alu_core: RTL and testbench
===============================

Name: seq_alu_core

Overview:
- Parametrised successor to the 8-bit opcode ALU: WIDTH-bit operands, 2-bit opcode, start/busy/done handshake.
- ADD and SUB complete in one cycle. MUL uses an iterative shift-add engine; DIV uses an iterative restoring divider.
- Adds status flags: carry/borrow, zero, divide-by-zero.
- Sits between the pin-level input decode and the output driver. The result is held stable until the next accepted operation.

Parameters:
- WIDTH, 8, operand width in bits; must be ≥ 2.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- CLK  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- op  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV (same encoding as IN7:IN6).
- a  input  WIDTH  operand A (dividend for DIV).
- b  input  WIDTH  operand B (divisor for DIV).
- result  output  2*WIDTH  registered result.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when result and flags update.
- cout  output  1  ADD: carry out; SUB: borrow (a<b); 0 for MUL/DIV.
- zero  output  1  result == 0.
- div_zero  output  1  DIV attempted with b == 0.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; result=0, busy=0, done=0, cout=0, zero=0, div_zero=0; internal operand, accumulator and counter registers are cleared.
- Accept: on a rising edge with state=IDLE and start=1, a, b and op are captured. Later changes on a, b and op have no effect on the operation in flight.
- start while busy=1 is ignored and not queued.
- States:
  - IDLE: waits for start.
  - EXEC: used by MUL and DIV only; runs WIDTH iterations.
  - FIN: drives the done pulse for one cycle, then returns to IDLE.
- ADD/SUB: IDLE→FIN on accept. result/flags are written on the accept edge, done=1 in the following cycle. Latency is 1 cycle. busy=0 throughout.
  - ADD: result = zero-extended (a+b), WIDTH+1 significant bits; cout = bit WIDTH.
  - SUB: result[WIDTH-1:0] = (a−b) mod 2^WIDTH; upper half = 0; cout = (a<b).
- MUL: unsigned shift-add, one multiplier bit per cycle.
  - IDLE→EXEC on accept; busy=1 from the cycle after accept.
  - After WIDTH EXEC cycles: result = a*b (full 2*WIDTH bits), done=1.
  - Latency is WIDTH+1 cycles from the accept edge to done.
- DIV: unsigned restoring division, one quotient bit per cycle, same timing as MUL.
  - result[WIDTH-1:0] = quotient; result[2*WIDTH-1:WIDTH] = remainder.
- DIV with b=0: no iteration. Goes IDLE→FIN with result = {a, all-ones}, div_zero=1, cout=0, latency 1.
  - div_zero clears on the next accepted operation.
- Output timing:
  - result, cout, zero and div_zero change only on the same edge that raises done.
  - They hold until the next operation completes.
  - zero is computed on the final 2*WIDTH result.
- done is high for exactly one cycle per accepted operation. busy drops in the same cycle done rises.
- A new start may be accepted in the cycle done is high (back-to-back operation).
- Reset during EXEC aborts the operation: no done pulse, and all outputs return to their reset values immediately.
- Counter wrap: the EXEC counter counts WIDTH−1 down to 0 and never wraps. Exit is on count==0.

Test Plan (WIDTH=8):
- Reset then ADD a=200, b=100 → result=0x012C, cout=1, zero=0; done one cycle after accept, busy never high.
- SUB a=5, b=9 → result=0x00FC, cout=1; then SUB a=9, b=9 → result=0x0000, zero=1, cout=0.
- MUL a=15, b=17 → busy for 8 cycles; done 9 cycles after accept; result=0x00FF. Also MUL 255×255 → 0xFE01.
- DIV a=100, b=7 → result=0x020E (remainder 2, quotient 14), done at cycle 9. DIV a=55, b=0 → result=0x37FF, div_zero=1, done at cycle 1.
- Start pulses with changing a/b during MUL are ignored and the original result is produced. Back-to-back ADD accepted in the done cycle completes correctly.
- Assert rst at cycle 4 of a DIV → outputs zero asynchronously and no done pulse; after release, ADD 1+1 → 0x0002.

Source files
------------

// File: rtl/seq_alu_core.sv
// Sequential unsigned ALU: single-cycle ADD/SUB, iterative shift-add MUL and
// restoring DIV behind a start/busy/done handshake with registered result and flags.
module seq_alu_core #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic                 done,
    output logic                 cout,
    output logic                 zero,
    output logic                 div_zero
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // One shift-add step: conditionally add the multiplicand into the upper half, then shift right.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                     input logic [WIDTH-1:0]   mcand,
                                                     input logic               mbit);
        logic [WIDTH:0] hi;
        hi = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mbit ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        return {hi, acc[WIDTH-1:1]};
    endfunction

    // One restoring step on {remainder, dividend/quotient}; the quotient bit enters at the LSB.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc,
                                                     input logic [WIDTH-1:0]   divisor);
        logic [WIDTH:0] shifted;
        logic [WIDTH:0] diff;
        shifted = acc[2*WIDTH-1:WIDTH-1];
        diff    = shifted - {1'b0, divisor};
        if (!diff[WIDTH]) begin
            return {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            return {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    endfunction

    logic [1:0]         state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cout_q, cout_d;
    logic               zero_q, zero_d;
    logic               div_zero_q, div_zero_d;

    logic               accept_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH-1:0]   diff_s;
    logic [2*WIDTH-1:0] step_s;

    // Next-state, datapath and output-register computation.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cout_d     = cout_q;
        zero_d     = zero_q;
        div_zero_d = div_zero_q;

        // FIN accepts like IDLE so back-to-back operations start in the done cycle.
        accept_s = start && ((state_q == ST_IDLE) || (state_q == ST_FIN));
        sum_s    = {1'b0, a} + {1'b0, b};
        diff_s   = a - b;
        if (op_q == OP_MUL) begin
            step_s = mul_step(acc_q, opb_q, opa_q[0]);
        end else begin
            step_s = div_step(acc_q, opb_q);
        end

        case (state_q)
            ST_IDLE, ST_FIN: begin
                if (accept_s) begin
                    op_d = op;
                    case (op)
                        OP_ADD: begin
                            result_d   = {{(WIDTH-1){1'b0}}, sum_s};
                            cout_d     = sum_s[WIDTH];
                            zero_d     = (sum_s == {(WIDTH+1){1'b0}});
                            div_zero_d = 1'b0;
                            done_d     = 1'b1;
                            state_d    = ST_FIN;
                        end
                        OP_SUB: begin
                            result_d   = {{WIDTH{1'b0}}, diff_s};
                            cout_d     = (a < b);
                            zero_d     = (diff_s == {WIDTH{1'b0}});
                            div_zero_d = 1'b0;
                            done_d     = 1'b1;
                            state_d    = ST_FIN;
                        end
                        OP_MUL: begin
                            opa_d   = a;
                            opb_d   = b;
                            acc_d   = {(2*WIDTH){1'b0}};
                            cnt_d   = CNT_W'(WIDTH - 1);
                            busy_d  = 1'b1;
                            state_d = ST_EXEC;
                        end
                        OP_DIV: begin
                            if (b == {WIDTH{1'b0}}) begin
                                result_d   = {a, {WIDTH{1'b1}}};
                                cout_d     = 1'b0;
                                zero_d     = 1'b0;
                                div_zero_d = 1'b1;
                                done_d     = 1'b1;
                                state_d    = ST_FIN;
                            end else begin
                                opa_d   = a;
                                opb_d   = b;
                                acc_d   = {{WIDTH{1'b0}}, a};
                                cnt_d   = CNT_W'(WIDTH - 1);
                                busy_d  = 1'b1;
                                state_d = ST_EXEC;
                            end
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                acc_d = step_s;
                opa_d = {1'b0, opa_q[WIDTH-1:1]};
                if (cnt_q == {CNT_W{1'b0}}) begin
                    result_d   = step_s;
                    cout_d     = 1'b0;
                    zero_d     = (step_s == {(2*WIDTH){1'b0}});
                    div_zero_d = 1'b0;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = ST_FIN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= 2'b00;
            opa_q      <= {WIDTH{1'b0}};
            opb_q      <= {WIDTH{1'b0}};
            acc_q      <= {(2*WIDTH){1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
            result_q   <= {(2*WIDTH){1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cout_q     <= 1'b0;
            zero_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cout_q     <= cout_d;
            zero_q     <= zero_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign result   = result_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign cout     = cout_q;
    assign zero     = zero_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_seq_alu_core.sv
// Scoreboard bench for seq_alu_core (WIDTH=8): expectations are queued at issue
// and compared, together with latency and busy length, when done pulses.
module tb_seq_alu_core;

    localparam int W = 8;

    logic           clk_s;
    logic           rst_s;
    logic           start_s;
    logic [1:0]     op_s;
    logic [W-1:0]   a_s;
    logic [W-1:0]   b_s;
    logic [2*W-1:0] result_s;
    logic           busy_s;
    logic           done_s;
    logic           cout_s;
    logic           zero_s;
    logic           div_zero_s;

    typedef struct {
        logic [2*W-1:0] res;
        logic           cout;
        logic           zero;
        logic           dz;
        int             lat;
        int             busy_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    seq_alu_core #(.WIDTH(W)) dut (
        .CLK      (clk_s),
        .rst      (rst_s),
        .start    (start_s),
        .op       (op_s),
        .a        (a_s),
        .b        (b_s),
        .result   (result_s),
        .busy     (busy_s),
        .done     (done_s),
        .cout     (cout_s),
        .zero     (zero_s),
        .div_zero (div_zero_s)
    );

    initial clk_s = 1'b0;
    always #5 clk_s = ~clk_s;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [W:0] s;
        e.cout = 1'b0; e.dz = 1'b0; e.lat = 1; e.busy_cyc = 0;
        case (op)
            2'b00: begin s = {1'b0, a} + {1'b0, b}; e.res = {7'h00, s}; e.cout = s[W]; end
            2'b01: begin e.res = {8'h00, a - b}; e.cout = (a < b); end
            2'b10: begin e.res = a * b; e.lat = W + 1; e.busy_cyc = W; end
            default: begin
                if (b == 8'h00) begin
                    e.res = {a, 8'hFF}; e.dz = 1'b1;
                end else begin
                    e.res = {a % b, a / b}; e.lat = W + 1; e.busy_cyc = W;
                end
            end
        endcase
        e.zero = (e.res == 16'h0000);
        return e;
    endfunction

    // Caller is at a negedge; request is presented for exactly one rising edge.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        sb_q.push_back(model(op, a, b));
        op_s = op; a_s = a; b_s = b; start_s = 1'b1;
        @(posedge clk_s);
        #1;
        start_s = 1'b0;
    endtask

    task automatic wait_done(input bit noise);
        int   cyc = 0;
        int   bcyc = 0;
        bit   seen = 1'b0;
        exp_t e;
        while (cyc < 40 && !seen) begin
            @(negedge clk_s);
            cyc++;
            if (done_s) begin
                seen    = 1'b1;
                start_s = 1'b0;
            end else begin
                if (busy_s) bcyc++;
                if (noise && busy_s) begin
                    start_s = 1'($urandom_range(0, 1));
                    op_s    = 2'($urandom_range(0, 3));
                    a_s     = 8'($urandom);
                    b_s     = 8'($urandom);
                end
            end
        end
        e = sb_q.pop_front();
        check_eq("done_seen", 64'(seen), 64'd1);
        if (seen) begin
            check_eq("result",   64'(result_s),   64'(e.res));
            check_eq("cout",     64'(cout_s),     64'(e.cout));
            check_eq("zero",     64'(zero_s),     64'(e.zero));
            check_eq("div_zero", 64'(div_zero_s), 64'(e.dz));
            check_eq("latency",  64'(cyc),        64'(e.lat));
            check_eq("busy_len", 64'(bcyc),       64'(e.busy_cyc));
            check_eq("busy_at_done", 64'(busy_s), 64'd0);
        end
    endtask

    initial begin
        int   done_during_rst;
        exp_t junk;
        rst_s = 1'b1; start_s = 1'b0; op_s = 2'b00; a_s = 8'h00; b_s = 8'h00;
        repeat (2) @(negedge clk_s);
        check_eq("rst_result", 64'(result_s), 64'd0);
        check_eq("rst_flags", 64'({busy_s, done_s, cout_s, zero_s, div_zero_s}), 64'd0);
        rst_s = 1'b0;

        @(negedge clk_s); issue(2'b00, 8'd200, 8'd100); wait_done(1'b0);
        @(negedge clk_s); issue(2'b01, 8'd5,   8'd9);   wait_done(1'b0);
        @(negedge clk_s); issue(2'b01, 8'd9,   8'd9);   wait_done(1'b0);
        @(negedge clk_s); issue(2'b10, 8'd15,  8'd17);  wait_done(1'b1);
        @(negedge clk_s); issue(2'b10, 8'd255, 8'd255); wait_done(1'b0);
        @(negedge clk_s); issue(2'b11, 8'd100, 8'd7);   wait_done(1'b0);
        @(negedge clk_s); issue(2'b11, 8'd55,  8'd0);   wait_done(1'b0);
        @(negedge clk_s); issue(2'b00, 8'd3,   8'd4);   wait_done(1'b0);
        repeat (3) @(negedge clk_s);
        check_eq("result_hold", 64'(result_s), 64'h0007);

        // Back-to-back: each new request is driven in the done cycle of the previous one.
        @(negedge clk_s); issue(2'b00, 8'd10,  8'd20); wait_done(1'b0);
        issue(2'b00, 8'd255, 8'd1);  wait_done(1'b0);
        issue(2'b10, 8'd12,  8'd13); wait_done(1'b0);
        issue(2'b11, 8'd200, 8'd9);  wait_done(1'b0);

        for (int i = 0; i < 6; i++) begin
            @(negedge clk_s);
            issue(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom_range(0, 255)));
            wait_done(1'b1);
        end

        // Reset in the middle of a DIV aborts it with no done pulse.
        @(negedge clk_s); issue(2'b11, 8'd100, 8'd7);
        repeat (3) @(negedge clk_s);
        rst_s = 1'b1;
        #1;
        check_eq("abort_result", 64'(result_s), 64'd0);
        check_eq("abort_flags", 64'({busy_s, done_s, cout_s, zero_s, div_zero_s}), 64'd0);
        junk = sb_q.pop_front();
        done_during_rst = 0;
        repeat (3) begin
            @(negedge clk_s);
            if (done_s) done_during_rst++;
        end
        rst_s = 1'b0;
        repeat (12) begin
            @(negedge clk_s);
            if (done_s) done_during_rst++;
        end
        check_eq("abort_no_done", 64'(done_during_rst), 64'd0);
        issue(2'b00, 8'd1, 8'd1); wait_done(1'b0);
        check_eq("abort_lost_res", 64'(junk.res), 64'h020E);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
